// File: rtl/essential_bit_sched.sv
// ============================================================================
// essential_bit_sched
// ----------------------------------------------------------------------------
// Beat scheduler that feeds the bit-serial shift-and-add lanes. It holds one
// group of LANES 5-bit essential-bit masks. Each beat it emits, for every lane,
// the position of that lane's leading one. When the beat is accepted, it
// clears that bit. A group therefore lasts max(1, max popcount) beats
// instead of a fixed 5.
//
// Optional feature: define BITSIM_SCHED_STAT_EN to build the saturating
// beat/group statistics counters. Without it, stat_* are tied to zero and no
// counter flops exist.
//
// Parameters
//   LANES  number of weight lanes (1..16)
//   CNT_W  statistics counter width
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     a new mask group is presented on in_mask
//   in_ready     the group on in_mask is accepted this cycle
//   in_mask      lane i at [5i+4:5i], bit 4 = MSB
//   out_valid    beat on out_shift/out_val is valid
//   out_ready    consumer accepts the beat
//   out_shift    per-lane shift code, lane i at [3i+2:3i] (bit4->0 .. bit0->4)
//   out_val      per-lane "bit present this beat"
//   out_last     final beat of the current group
//   stat_beats   saturating count of accepted beats
//   stat_groups  saturating count of completed groups
// ============================================================================
module essential_bit_sched #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*5-1:0]   in_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*3-1:0]   out_shift,
    output logic [LANES-1:0]     out_val,
    output logic                 out_last,
    output logic [CNT_W-1:0]     stat_beats,
    output logic [CNT_W-1:0]     stat_groups
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [LANES*5-1:0]    mask_reg;
    logic [LANES*5-1:0]    mask_next;

    // Per-lane encoder results, computed from the held mask only.
    logic [LANES*5-1:0]    mask_cleared;
    logic [LANES*3-1:0]    shift_enc;
    logic [LANES-1:0]      val_enc;
    logic                  all_clear;
    logic                  beat_fire;

    // ------------------------------------------------------------------------
    // Per-lane leading-one encoder and "mask after this beat"
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [4:0] lane_m;
            logic [4:0] lane_clr;
            logic [2:0] lane_sh;

            assign lane_m = mask_reg[5*gi +: 5];

            always_comb begin
                lane_sh  = 3'd0;
                lane_clr = lane_m;
                if (lane_m[4]) begin
                    lane_sh     = 3'd0;
                    lane_clr[4] = 1'b0;
                end else if (lane_m[3]) begin
                    lane_sh     = 3'd1;
                    lane_clr[3] = 1'b0;
                end else if (lane_m[2]) begin
                    lane_sh     = 3'd2;
                    lane_clr[2] = 1'b0;
                end else if (lane_m[1]) begin
                    lane_sh     = 3'd3;
                    lane_clr[1] = 1'b0;
                end else if (lane_m[0]) begin
                    lane_sh     = 3'd4;
                    lane_clr[0] = 1'b0;
                end
            end

            assign shift_enc[3*gi +: 3]    = lane_sh;
            assign val_enc[gi]             = |lane_m;
            assign mask_cleared[5*gi +: 5] = lane_clr;
        end
    endgenerate

    // The beat is the last one when removing every leading one empties the
    // whole group. An all-zero group satisfies this on its single beat.
    assign all_clear = (mask_cleared == '0);
    assign beat_fire = out_valid && out_ready;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                    mask_next  = in_mask;
                end
            end
            RUN: begin
                if (beat_fire) begin
                    if (all_clear) begin
                        // Group terminator accepted: either chain straight
                        // into the next group or drop back to IDLE.
                        if (in_valid) begin
                            mask_next = in_mask;
                        end else begin
                            state_next = IDLE;
                            mask_next  = '0;
                        end
                    end else begin
                        mask_next = mask_cleared;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                mask_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: driven from state/mask only, except in_ready which must see
    // out_ready to allow bubble-free back-to-back groups.
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        out_val   = '0;
        out_shift = '0;
        out_last  = 1'b0;
        in_ready  = 1'b1;
        if (state_reg == RUN) begin
            out_valid = 1'b1;
            out_val   = val_enc;
            out_shift = shift_enc;
            out_last  = all_clear;
            in_ready  = out_ready && all_clear;
        end
    end

    // ------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------
`ifdef BITSIM_SCHED_STAT_EN
    logic [CNT_W-1:0] beats_reg;
    logic [CNT_W-1:0] groups_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_reg  <= '0;
            groups_reg <= '0;
        end else begin
            if (beat_fire && (beats_reg != '1)) begin
                beats_reg <= beats_reg + 1'b1;
            end
            if (beat_fire && out_last && (groups_reg != '1)) begin
                groups_reg <= groups_reg + 1'b1;
            end
        end
    end

    assign stat_beats  = beats_reg;
    assign stat_groups = groups_reg;
`else
    assign stat_beats  = '0;
    assign stat_groups = '0;
`endif

endmodule

// File: tb/tb_essential_bit_sched.sv
module tb_essential_bit_sched;

    localparam int LANES = 4;
    localparam int CNT_W = 4;

`ifdef BITSIM_SCHED_STAT_EN
    localparam int STAT_SAT = 15;
    localparam int STAT_MID = 10;
`else
    localparam int STAT_SAT = 0;
    localparam int STAT_MID = 0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*5-1:0]   in_mask;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*3-1:0]   out_shift;
    logic [LANES-1:0]     out_val;
    logic                 out_last;
    logic [CNT_W-1:0]     stat_beats;
    logic [CNT_W-1:0]     stat_groups;

    int checks = 0;
    int errors = 0;

    essential_bit_sched #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mask     (in_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_shift   (out_shift),
        .out_val     (out_val),
        .out_last    (out_last),
        .stat_beats  (stat_beats),
        .stat_groups (stat_groups)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one presented beat, then let the clock edge pass (out_ready as driven).
    task automatic beat(input string tag, input logic [3:0] ev, input logic [11:0] es,
                        input logic el, input logic er);
        $display("beat %-10s valid=%0b val=%b shift=%h last=%0b in_ready=%0b",
                 tag, out_valid, out_val, out_shift, out_last, in_ready);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".val"},   32'(out_val),   32'(ev));
        check({tag, ".shift"}, 32'(out_shift), 32'(es));
        check({tag, ".last"},  32'(out_last),  32'(el));
        check({tag, ".ready"}, 32'(in_ready),  32'(er));
        step();
    endtask

    // Present a group while idle and let it be accepted on the next edge.
    task automatic load(input string tag, input logic [19:0] m);
        in_valid = 1'b1;
        in_mask  = m;
        #0;
        check({tag, ".load_rdy"}, 32'(in_ready), 32'd1);
        $display("load %-10s mask=%h", tag, m);
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".idle_rdy"},   32'(in_ready),  32'd1);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        out_ready = 1'b1;

        // Reset values
        #2;
        check("rst.valid",  32'(out_valid),   32'd0);
        check("rst.val",    32'(out_val),     32'd0);
        check("rst.shift",  32'(out_shift),   32'd0);
        check("rst.last",   32'(out_last),    32'd0);
        check("rst.ready",  32'(in_ready),    32'd1);
        check("rst.sbeats", 32'(stat_beats),  32'd0);
        check("rst.sgroup", 32'(stat_groups), 32'd0);
        #6;
        rst_n = 1'b1;
        step();
        expect_idle("post_rst");

        // Mixed group: lane0=10110, lane1=00001, lane2=00000, lane3=11111.
        // Shift word lanes: lane0 [2:0], lane1 [5:3], lane2 [8:6], lane3 [11:9].
        load("mix", {5'b11111, 5'b00000, 5'b00001, 5'b10110});
        beat("mix.b1", 4'b1011, 12'h020, 1'b0, 1'b0); // l0=0 l1=4 l3=0
        beat("mix.b2", 4'b1001, 12'h202, 1'b0, 1'b0); // l0=2 l3=1
        beat("mix.b3", 4'b1001, 12'h403, 1'b0, 1'b0); // l0=3 l3=2
        beat("mix.b4", 4'b1000, 12'h600, 1'b0, 1'b0); // l3=3
        beat("mix.b5", 4'b1000, 12'h800, 1'b1, 1'b1); // l3=4, last
        expect_idle("mix.end");

        // All-zero group still yields one terminating beat
        load("zero", 20'h0);
        beat("zero.b1", 4'b0000, 12'h000, 1'b1, 1'b1);
        expect_idle("zero.end");

        // Back-to-back: A = lane0 00011 (2 beats), B = lane1 10000 (1 beat)
        in_valid = 1'b1;
        in_mask  = {5'b0, 5'b0, 5'b0, 5'b00011};
        step();
        in_mask  = {5'b0, 5'b0, 5'b10000, 5'b0};
        beat("b2b.a1", 4'b0001, 12'h003, 1'b0, 1'b0);
        beat("b2b.a2", 4'b0001, 12'h004, 1'b1, 1'b1);
        in_valid = 1'b0;
        beat("b2b.b1", 4'b0010, 12'h000, 1'b1, 1'b1);
        expect_idle("b2b.end");

        // Stall: lane2 11100 (3 beats), out_ready 1,0,0,1 then 1
        load("stall", {5'b0, 5'b11100, 5'b0, 5'b0});
        beat("stall.b1", 4'b0100, 12'h000, 1'b0, 1'b0);
        out_ready = 1'b0;
        beat("stall.h1", 4'b0100, 12'h040, 1'b0, 1'b0);
        beat("stall.h2", 4'b0100, 12'h040, 1'b0, 1'b0);
        out_ready = 1'b1;
        beat("stall.b2", 4'b0100, 12'h040, 1'b0, 1'b0);
        beat("stall.b3", 4'b0100, 12'h080, 1'b1, 1'b1);
        expect_idle("stall.end");

        // Reset during beat 2 of a 4-beat group: lane0 01111
        load("rstmid", {5'b0, 5'b0, 5'b0, 5'b01111});
        beat("rstmid.b1", 4'b0001, 12'h001, 1'b0, 1'b0);
        check("rstmid.b2shift", 32'(out_shift), 32'h002);
        rst_n = 1'b0;
        #1;
        check("rstmid.valid", 32'(out_valid), 32'd0);
        check("rstmid.val",   32'(out_val),   32'd0);
        check("rstmid.last",  32'(out_last),  32'd0);
        check("rstmid.ready", 32'(in_ready),  32'd1);
        check("rstmid.mask",  32'(dut.mask_reg), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        expect_idle("rstmid.idle");
        load("after", {5'b00100, 5'b0, 5'b0, 5'b0});
        beat("after.b1", 4'b1000, 12'h400, 1'b1, 1'b1);
        expect_idle("after.end");

        // Statistics: 20 single-beat groups from a clean reset
        reset_pulse();
        check("stat.clr_beats",  32'(stat_beats),  32'd0);
        check("stat.clr_groups", 32'(stat_groups), 32'd0);
        for (int g = 0; g < 20; g++) begin
            load("sgrp", {5'b0, 5'b0, 5'b0, 5'b10000});
            beat("sgrp.b1", 4'b0001, 12'h000, 1'b1, 1'b1);
            if (g == 9) begin
                check("stat.mid_beats",  32'(stat_beats),  32'(STAT_MID));
                check("stat.mid_groups", 32'(stat_groups), 32'(STAT_MID));
            end
        end
        check("stat.sat_beats",  32'(stat_beats),  32'(STAT_SAT));
        check("stat.sat_groups", 32'(stat_groups), 32'(STAT_SAT));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/essential_bit_sched.md
# essential_bit_sched

Sequential scheduler that sits directly upstream of the 5-to-3 priority encoder in the bit-serial PE datapath. It holds one group of LANES 5-bit essential-bit masks and, each cycle, uses per-lane leading-one encoding to emit one shift amount per lane. It then clears the emitted bit, repeating until every lane's mask is empty. Downstream shift-and-add lanes consume one beat per cycle under a valid/ready handshake, so a group occupies max(popcount) cycles instead of a fixed 5.

## Interface
- LANES, default 4: number of parallel weight lanes, range 1..16.
- CNT_W, default 16: width of the statistics counters, active only when the configuration macro is defined.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  a new mask group is presented
- in_ready  output  1  the scheduler accepts the group this cycle
- in_mask  input  LANES*5  lane i is at bits [5i+4:5i]; bit 4 is the MSB
- out_valid  output  1  the beat on out_shift/out_val is valid
- out_ready  input  1  the consumer accepts the beat
- out_shift  output  LANES*3  per-lane shift code; lane i is at [3i+2:3i]
- out_val  output  LANES  per-lane "bit present this beat"
- out_last  output  1  this beat is the final beat of the group
- stat_beats  output  CNT_W  total beats accepted downstream
- stat_groups  output  CNT_W  total groups completed

## Operation
- The block has two states:
  - IDLE: no group is held; out_valid=0.
  - RUN: a group is held in mask_q[LANES*5]; out_valid=1.
- Load: when in_valid && in_ready, mask_q is set to in_mask and the state becomes RUN.
- Per-lane encode in RUN, from the lane's mask_q:
  - out_val[i] = (mask_q lane i != 0).
  - out_shift[i] is the leading-one position mapped as bit4->0, bit3->1, bit2->2, bit1->3, bit0->4.
  - Lanes with out_val[i]=0 drive out_shift[i]=0, never X.
- Beat consumption: on out_valid && out_ready, every lane with out_val=1 clears its leading-one bit in mask_q.
- out_last = 1 when every lane has at most one set bit, i.e. the next mask after clearing is all zero.
- All-zero group: an accepted all-zero group still produces exactly one beat, with out_val=0 in all lanes and out_last=1. The consumer always sees a group terminator.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This allows back-to-back groups with no bubble, and in_ready is combinational on out_ready.
- Completion:
  - Last beat accepted and a new group accepted the same cycle: reload and stay in RUN.
  - Last beat accepted and no new group: go to IDLE.
- Backpressure: while out_ready=0, mask_q, out_shift, out_val and out_last hold stable.

## Timing
- Reset values (asynchronous assertion; state releases on the first clk edge after rst_n rises):
  - state=IDLE, mask_q=0
  - out_valid=0, out_val=0, out_shift=0, out_last=0
  - in_ready=1
  - stats=0
- Latency: a group accepted at edge N presents its first beat after edge N, in the same cycle as RUN.
- Group duration is max(1, max over lanes of popcount(mask)) accepted beats, at most 5.
- out_* outputs are combinational from mask_q/state only; there is no path from in_* to out_*.
- Reset mid-group: the group is discarded and no out_last is produced for it.

## Configuration
- BITSIM_SCHED_STAT_EN defined: two statistics counters are built.
  - stat_beats increments on each out_valid && out_ready.
  - stat_groups increments on each accepted beat with out_last=1.
  - Both saturate at 2^CNT_W-1 and clear only on reset.
- BITSIM_SCHED_STAT_EN undefined: no counter flops are built and stat_beats = stat_groups = 0.
- The ports exist in both builds.

## Test plan
- LANES=4, in_mask lanes = {5'b10110, 5'b00001, 5'b00000, 5'b11111}, out_ready=1:
  - The group runs 5 beats.
  - Lane 0 shifts 0,2,3; lane 1 shifts 4; lane 3 shifts 0,1,2,3,4.
  - Lane 2 has out_val=0 throughout.
  - out_last=1 only on beat 5, and in_ready=1 on that cycle.
- All-zero group: the block emits one beat with out_val=4'b0000 and out_last=1, then returns to IDLE.
- Back-to-back groups with in_valid held high: the second group's first beat appears the cycle after the first group's last beat, with no idle cycle.
- out_ready toggled 1,0,0,1 mid-group: outputs hold exactly during the stalls, and the beat count is unchanged.
- rst_n pulsed low during beat 2 of a 4-beat group:
  - out_valid drops immediately, mask_q=0 and in_ready=1.
  - The next group runs normally.
- With BITSIM_SCHED_STAT_EN and CNT_W=4, run 20 single-beat groups: stat_beats=15 and stat_groups=15 (saturated). Without the macro, both stay 0.
